// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the single-clock and dual-clock FIFOs.
//   FIFO_DATA_WIDTH : default word width in bits
//   FIFO_ADDR_WIDTH : default address width (depth = 2**FIFO_ADDR_WIDTH)
//   level_width()   : bits needed to hold an occupancy count of 0..depth
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 4;
    localparam int FIFO_ADDR_WIDTH = 3;

    // Smallest w such that 2**w > depth, i.e. enough bits to count 0..depth.
    // For a power-of-two depth this is log2(depth) + 1.
    function automatic int level_width(input int depth);
        int w;
        w = 0;
        while ((1 << w) <= depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ram_1c.sv
// -----------------------------------------------------------------------------
// fifo_ram_1c
// Single-clock storage array, 2**ADDR_WIDTH x DATA_WIDTH.
// Synchronous write port, asynchronous (combinational) read port, no reset:
// contents are undefined until written.
//   clk_i      : write clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write index
//   wr_data_i  : write word
//   rd_addr_i  : read index
//   rd_data_o  : word at rd_addr_i, same cycle
// -----------------------------------------------------------------------------
module fifo_ram_1c
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : fifo_ram_1c

// File: rtl/sync_fifo_level.sv
// -----------------------------------------------------------------------------
// sync_fifo_level
// Single-clock FIFO with registered occupancy count, threshold flags, sticky
// error flags and a choice of registered or first-word-fall-through read.
//
// Handshake: a write is taken on a rising edge when wr_en=1 and full=0; a read
// is taken when rd_en=1 and empty=0. Both decisions use the registered flags
// as they stand before the edge, so a write never satisfies a read in the same
// cycle. rd_valid qualifies rd_data (a one-cycle pulse per read in registered
// mode, level-sensitive ~empty in FWFT mode).
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr_en, wr_data        : write request and word
//   rd_en                 : read request (pops the head word)
//   clr_err               : synchronous clear of overflow/underflow
//   rd_data, rd_valid     : read word and its qualifier
//   full, empty           : occupancy flags
//   almost_full/empty     : threshold flags (level >= AFULL, level <= AEMPTY)
//   level                 : stored word count 0..depth
//   overflow, underflow   : sticky error flags
// -----------------------------------------------------------------------------
module sync_fifo_level
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2,
    parameter bit FWFT          = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LVL_W = level_width(DEPTH);

    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AFULL_L  = LVL_W'(AFULL_THRESH);
    localparam logic [LVL_W-1:0] AEMPTY_L = LVL_W'(AEMPTY_THRESH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q,  level_d;
    logic                full_q,   full_d;
    logic                empty_q,  empty_d;
    logic                afull_q,  afull_d;
    logic                aempty_q, aempty_d;
    logic                ovf_q,    ovf_d;
    logic                udf_q,    udf_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // The pointer MSB only distinguishes laps; occupancy comes from level_q.
    logic ptr_msb_unused;
    assign ptr_msb_unused = wr_ptr_q[ADDR_WIDTH] ^ rd_ptr_q[ADDR_WIDTH];

    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Flags derive from the next level so they change on the same edge.
        full_d   = (level_d == DEPTH_L);
        empty_d  = (level_d == '0);
        afull_d  = (level_d >= AFULL_L);
        aempty_d = (level_d <= AEMPTY_L);

        // Set has priority over clear so an error in the clearing cycle is kept.
        ovf_d = ovf_q;
        if (wr_en & full_q) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end

        udf_d = udf_q;
        if (rd_en & empty_q) begin
            udf_d = 1'b1;
        end else if (clr_err) begin
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    fifo_ram_1c #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (ram_rd_data)
    );

    // ------------------------------------------------------------------
    // Read output
    // ------------------------------------------------------------------
    generate
        if (FWFT) begin : g_fwft
            // Head word is shown directly; masked while empty so the
            // un-reset memory never leaks onto rd_data.
            assign rd_data  = empty_q ? '0 : ram_rd_data;
            assign rd_valid = ~empty_q;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= ram_rd_data;
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule : sync_fifo_level

// File: tb/tb_sync_fifo_level.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_level
// Drives one registered-read instance (suffix _a) and one FWFT instance
// (suffix _b) with identical stimulus and checks both against a reference
// model: occupancy counter, error flags and an expected-data queue.
// -----------------------------------------------------------------------------
module tb_sync_fifo_level;

  localparam int DW    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFULL = 6;
  localparam int AEMPT = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;

  // instance A outputs (registered read)
  logic [DW-1:0] rd_data_a;
  logic          rd_valid_a, full_a, empty_a, afull_a, aempty_a, ovf_a, udf_a;
  logic [AW:0]   level_a;

  // instance B outputs (FWFT)
  logic [DW-1:0] rd_data_b;
  logic          rd_valid_b, full_b, empty_b, afull_b, aempty_b, ovf_b, udf_b;
  logic [AW:0]   level_b;

  sync_fifo_level #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AFULL),
    .AEMPTY_THRESH(AEMPT), .FWFT(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .full(full_a), .empty(empty_a),
    .almost_full(afull_a), .almost_empty(aempty_a), .level(level_a),
    .overflow(ovf_a), .underflow(udf_a)
  );

  sync_fifo_level #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AFULL),
    .AEMPTY_THRESH(AEMPT), .FWFT(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .full(full_b), .empty(empty_b),
    .almost_full(afull_b), .almost_empty(aempty_b), .level(level_b),
    .overflow(ovf_b), .underflow(udf_b)
  );

  // scoreboard / model
  logic [DW-1:0] exp_q[$];
  int            m_level = 0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic [DW-1:0] m_rd = '0;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every status output of both instances with the model.
  task automatic check_all(input string tag);
    logic [31:0] lvl;
    lvl = 32'(m_level);
    check({tag, ":level_a"}, 32'(level_a), lvl);
    check({tag, ":level_b"}, 32'(level_b), lvl);
    check({tag, ":full_a"}, 32'(full_a), 32'(m_level == DEPTH));
    check({tag, ":full_b"}, 32'(full_b), 32'(m_level == DEPTH));
    check({tag, ":empty_a"}, 32'(empty_a), 32'(m_level == 0));
    check({tag, ":empty_b"}, 32'(empty_b), 32'(m_level == 0));
    check({tag, ":afull_a"}, 32'(afull_a), 32'(m_level >= AFULL));
    check({tag, ":afull_b"}, 32'(afull_b), 32'(m_level >= AFULL));
    check({tag, ":aempty_a"}, 32'(aempty_a), 32'(m_level <= AEMPT));
    check({tag, ":aempty_b"}, 32'(aempty_b), 32'(m_level <= AEMPT));
    check({tag, ":ovf_a"}, 32'(ovf_a), 32'(m_ovf));
    check({tag, ":ovf_b"}, 32'(ovf_b), 32'(m_ovf));
    check({tag, ":udf_a"}, 32'(udf_a), 32'(m_udf));
    check({tag, ":udf_b"}, 32'(udf_b), 32'(m_udf));
    check({tag, ":rd_data_a"}, 32'(rd_data_a), 32'(m_rd));
    check({tag, ":rd_valid_b"}, 32'(rd_valid_b), 32'(m_level > 0));
    if (m_level > 0) begin
      check({tag, ":head_b"}, 32'(rd_data_b), 32'(exp_q[0]));
    end else begin
      check({tag, ":rd_data_b_empty"}, 32'(rd_data_b), 32'd0);
    end
  endtask

  // One clock cycle of stimulus: model updated before the edge, DUT checked
  // 1 time unit after it.
  task automatic cycle(input string tag, input logic w, input logic [DW-1:0] d,
                       input logic r, input logic c);
    logic wacc, racc;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr_err = c;
    wacc = w && (m_level < DEPTH);
    racc = r && (m_level > 0);
    if (w && (m_level == DEPTH)) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (r && (m_level == 0)) m_udf = 1'b1;
    else if (c) m_udf = 1'b0;
    if (racc) m_rd = exp_q.pop_front();
    if (wacc) exp_q.push_back(d);
    m_level = m_level + int'(wacc) - int'(racc);
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    check({tag, ":rd_valid_a"}, 32'(rd_valid_a), 32'(racc));
    check_all(tag);
  endtask

  task automatic model_reset();
    m_level = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_rd    = '0;
    exp_q.delete();
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- reset and idle ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset:rd_valid_a", 32'(rd_valid_a), 32'd0);
    check_all("reset");
    cycle("idle", 1'b0, 4'h0, 1'b0, 1'b0);

    // ---- fill 0x1..0x8, flags walk through thresholds ----
    for (int i = 1; i <= 8; i++) begin
      cycle("fill", 1'b1, DW'(i), 1'b0, 1'b0);
    end
    // ---- drain 8, registered data 1 cycle after rd_en ----
    for (int i = 1; i <= 8; i++) begin
      cycle("drain", 1'b0, 4'h0, 1'b1, 1'b0);
      check("drain:order", 32'(rd_data_a), 32'(i));
    end
    cycle("post_drain", 1'b0, 4'h0, 1'b0, 1'b0);

    // ---- refill, then write+read while full ----
    for (int i = 0; i < 8; i++) begin
      cycle("refill", 1'b1, DW'($urandom_range(0, 15)), 1'b0, 1'b0);
    end
    cycle("full_wr_rd", 1'b1, 4'h9, 1'b1, 1'b0);
    check("full_wr_rd:level7", 32'(level_a), 32'd7);
    check("full_wr_rd:ovf", 32'(ovf_a), 32'd1);
    cycle("clr_ovf", 1'b0, 4'h0, 1'b0, 1'b1);
    check("clr_ovf:ovf", 32'(ovf_b), 32'd0);
    // drain all 7; 0x9 must never appear (model never queued it)
    for (int i = 0; i < 7; i++) begin
      cycle("drain2", 1'b0, 4'h0, 1'b1, 1'b0);
    end

    // ---- empty with read+write ----
    cycle("empty_rd_wr", 1'b1, 4'hA, 1'b1, 1'b0);
    check("empty_rd_wr:udf", 32'(udf_a), 32'd1);
    check("empty_rd_wr:fwft_valid", 32'(rd_valid_b), 32'd1);
    check("empty_rd_wr:fwft_data", 32'(rd_data_b), 32'hA);
    cycle("pop_a", 1'b0, 4'h0, 1'b1, 1'b0);
    check("pop_a:data", 32'(rd_data_a), 32'hA);
    // underflow set in the same cycle as clr_err: set wins
    cycle("udf_vs_clr", 1'b0, 4'h0, 1'b1, 1'b1);
    check("udf_vs_clr:udf", 32'(udf_a), 32'd1);
    cycle("clr_udf", 1'b0, 4'h0, 1'b0, 1'b1);

    // ---- stream at level 4, pointers wrap ----
    for (int i = 0; i < 4; i++) begin
      cycle("pre_stream", 1'b1, DW'($urandom_range(0, 15)), 1'b0, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      cycle("stream", 1'b1, DW'($urandom_range(0, 15)), 1'b1, 1'b0);
      check("stream:level4", 32'(level_b), 32'd4);
    end

    // ---- asynchronous reset at level 5 ----
    cycle("to5", 1'b1, DW'($urandom_range(0, 15)), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst:rd_valid_a", 32'(rd_valid_a), 32'd0);
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("after_rst_wr", 1'b1, 4'h3, 1'b0, 1'b0);
    cycle("after_rst_rd", 1'b0, 4'h0, 1'b1, 1'b0);
    check("after_rst_rd:data", 32'(rd_data_a), 32'h3);
    cycle("final_idle", 1'b0, 4'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sync_fifo_level
